fetch_operand: RTL and testbench
================================

# fetch_operand

Upstream feeder for the shift/arithmetic ALU: fetches 32-bit instructions over a request/acknowledge instruction-memory port and reads the ALU's source operand from an internal 32x32 register file. It presents the instruction word and operand as a registered pair, using a valid/ready handshake. Results return from the ALU's downstream writeback path through the register-file write port.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  instruction read request.
- imem_addr  output  32  byte address of the instruction, equal to pc.
- imem_ack  input  1  read data valid this cycle.
- imem_rdata  input  32  instruction word.
- wb_en  input  1  register-file write enable.
- wb_addr  input  5  write index.
- wb_data  input  32  write data, the ALU result c.
- out_instr  output  32  instruction to the ALU's i_datain.
- out_gr1  output  32  operand to the ALU's gr1, equal to RF[out_instr[20:16]].
- out_valid  output  1  out_instr and out_gr1 are valid.
- out_ready  input  1  downstream accepts this cycle.

## Operation
- FSM states:
  - RST_S: entered on reset; no request issued.
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: out_valid=1, waiting for out_ready.
- Transitions:
  - RST_S -> FETCH on the first clk edge after rst deasserts.
  - FETCH -> HOLD on an edge where imem_ack=1.
  - HOLD -> FETCH on an edge where out_ready=1.
- imem_req and out_valid decode directly from state.
- Capture on the FETCH ack edge:
  - out_instr <= imem_rdata; pc <= pc + 4.
  - out_gr1 <= operand read from index imem_rdata[20:16].
- Operand read rules:
  - Index 0 reads 0.
  - If wb_en=1, wb_addr equals the index, and the index is nonzero, the value is wb_data (same-cycle bypass).
  - Otherwise the value is RF[index].
- Coherence in HOLD: if wb_en=1 and wb_addr==out_instr[20:16]!=0, out_gr1 <= wb_data on that edge, so the held operand never goes stale.
- Register file:
  - On each edge with wb_en=1 and wb_addr!=0, RF[wb_addr] <= wb_data.
  - Writes to index 0 are discarded.
  - Writes are accepted in every state except during reset.
- imem_ack is ignored outside FETCH.
- imem_rdata is sampled only on the ack edge.
- pc arithmetic is 32-bit unsigned and wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).

## Timing
- Reset values (immediately on rst assertion, independent of clk):
  - state=RST_S, pc=RESET_PC.
  - out_instr=0, out_gr1=0, out_valid=0, imem_req=0, imem_addr=RESET_PC.
  - All RF entries = 0.
- Reset mid-operation:
  - Aborts any outstanding request.
  - An ack arriving during reset is dropped.
  - Fetch restarts at RESET_PC.
- First request: imem_req goes high in the cycle after the first post-reset edge.
- Latency:
  - out_valid rises on the edge that samples imem_ack.
  - Zero-wait memory (ack in the first FETCH cycle) gives one instruction per 2 cycles at best.
- Handshake:
  - out_instr and out_gr1 are stable while out_valid=1 and out_ready=0, except for the coherence update above.
  - Transfer occurs on an edge with out_valid=1 and out_ready=1.
  - out_valid drops on that edge.
  - out_ready is ignored while out_valid=0.
- Simultaneous events:
  - Ack and wb to the captured rt on the same edge: out_gr1 takes wb_data.
  - out_ready and wb to rt on the same edge: the transfer completes with the pre-edge out_gr1 value, and RF is still updated.

## Test plan
- Reset: assert rst mid-FETCH with imem_ack=1 -> all outputs 0, imem_addr=RESET_PC; after release, imem_req=1 one cycle later at address 0.
- Basic fetch, then ALU check:
  - Setup: preload RF[9]=0x0000_0003 via wb; ack 0x0009_4080 (sll $8,$9,2) at pc 0.
  - Expected: out_instr=0x0009_4080, out_gr1=3, out_valid=1, next imem_addr=4; the ALU c reads 0xC.
- Same-edge bypass: ack an instruction with rt=5 on the edge where wb_en=1, wb_addr=5, wb_data=0xDEAD_BEEF -> out_gr1=0xDEAD_BEEF, and RF[5] holds it afterwards.
- Stall with coherence:
  - Hold out_ready=0 for 5 cycles; in cycle 3 write wb_addr=rt, wb_data=0x1234.
  - Expected: out_valid stays 1, out_gr1 becomes 0x1234, out_instr unchanged, imem_req=0 throughout.
- Register zero: wb_en=1, wb_addr=0, wb_data=0xFFFF_FFFF, then fetch an instruction with rt=0 -> out_gr1=0.
- PC wrap: RESET_PC=0xFFFF_FFFC; after one accepted fetch -> imem_addr=0x0000_0000.

Source files
------------

// File: rtl/fetch_operand_if.sv
// fetch_operand_if: bundles the instruction-memory port, the register-file
// writeback port and the instruction/operand output handshake of
// fetch_operand.
//
// Handshake: on the output side a transfer happens on a rising clk edge where
// out_valid=1 and out_ready=1. out_instr/out_gr1 hold while out_valid=1 and
// out_ready=0 (apart from the writeback coherence update of out_gr1).
// out_ready is don't-care while out_valid=0. On the memory side imem_req is
// high for as long as a fetch is outstanding. imem_ack=1 completes that fetch
// with imem_rdata in the same cycle.
//
//   master : the fetch_operand side (drives imem_req/imem_addr, out_*)
//   slave  : the environment side (memory, writeback path, ALU)
interface fetch_operand_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] out_instr;
  logic [31:0] out_gr1;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  wb_en, wb_addr, wb_data,
    output out_instr, out_gr1, out_valid,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output wb_en, wb_addr, wb_data,
    input  out_instr, out_gr1, out_valid,
    output out_ready
  );
endinterface

// File: rtl/fetch_operand.sv
// fetch_operand: fetches 32-bit instructions over a request/acknowledge
// memory port. It reads the source operand RF[instr[20:16]] from an internal
// 32x32 register file and presents {instr, operand} as a registered pair
// with a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        fetch_operand_if.master (imem_*, wb_*, out_*)
//   state_dbg  current FSM state (0=RST_S, 1=FETCH, 2=HOLD)
module fetch_operand #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  fetch_operand_if.master        bus,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    RST_S = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] gr1_q;
  logic [31:0] rf [0:31];

  logic [4:0]  fetch_rt;
  logic [31:0] fetch_opnd;
  logic        wb_hits_held_rt;

  // Operand for the instruction arriving this cycle. A write to the same
  // register on this edge is forwarded so the captured operand is never one
  // write behind. Index 0 always reads as zero.
  always_comb begin
    fetch_rt   = bus.imem_rdata[20:16];
    fetch_opnd = rf[fetch_rt];
    if (fetch_rt == 5'd0) begin
      fetch_opnd = '0;
    end else if (bus.wb_en && (bus.wb_addr == fetch_rt)) begin
      fetch_opnd = bus.wb_data;
    end
  end

  // A writeback to the register the held instruction reads refreshes the
  // held operand while the pair waits for the consumer.
  assign wb_hits_held_rt = bus.wb_en && (bus.wb_addr != 5'd0) &&
                           (bus.wb_addr == instr_q[20:16]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RST_S;
      pc      <= RESET_PC;
      instr_q <= '0;
      gr1_q   <= '0;
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (bus.wb_en && (bus.wb_addr != 5'd0)) begin
        rf[bus.wb_addr] <= bus.wb_data;
      end

      case (state)
        RST_S: begin
          state <= FETCH;
        end
        FETCH: begin
          if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            gr1_q   <= fetch_opnd;
            pc      <= pc + 32'd4;
            state   <= HOLD;
          end
        end
        HOLD: begin
          // On a transfer edge the pair leaves with its pre-edge operand.
          if (bus.out_ready) begin
            state <= FETCH;
          end else if (wb_hits_held_rt) begin
            gr1_q <= bus.wb_data;
          end
        end
        default: begin
          state <= RST_S;
        end
      endcase
    end
  end

  assign bus.imem_req  = (state == FETCH);
  assign bus.imem_addr = pc;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_instr = instr_q;
  assign bus.out_gr1   = gr1_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_fetch_operand.sv
module tb_fetch_operand;

  logic clk;
  logic rst;
  logic [1:0] state_dbg;
  logic [1:0] state_dbg_w;

  fetch_operand_if bus ();
  fetch_operand_if bus_w ();

  fetch_operand #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  fetch_operand #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_w.master),
    .state_dbg (state_dbg_w)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard counters
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({name, "_req"}, {31'd0, bus.imem_req}, 32'd1);
  endtask

  typedef struct {
    logic        pre_en;
    logic [4:0]  pre_addr;
    logic [31:0] pre_data;
    logic        ack_wb_en;
    logic [4:0]  ack_wb_addr;
    logic [31:0] ack_wb_data;
    logic [31:0] rdata;
    logic [31:0] exp_gr1;
  } vec_t;

  vec_t vecs [8];
  logic [31:0] exp_pc;
  logic [31:0] alu_c;

  initial begin
    // field order: pre_en, pre_addr, pre_data, ack_wb_en, ack_wb_addr, ack_wb_data, rdata, exp_gr1
    vecs[0] = '{1'b1, 5'd9,  32'h0000_0003, 1'b0, 5'd0,  32'h0,         32'h0009_4080, 32'h0000_0003};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         32'h0007_0000, 32'h0000_0000};
    vecs[2] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  32'hDEAD_BEEF, 32'h0005_2820, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,         32'h0000_1000, 32'h0000_0000};
    vecs[4] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         32'h0005_0000, 32'hDEAD_BEEF};
    vecs[5] = '{1'b1, 5'd31, 32'hA5A5_0001, 1'b1, 5'd30, 32'h0000_0077, 32'h001F_0000, 32'hA5A5_0001};
    vecs[6] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         32'h001E_0000, 32'h0000_0077};
    vecs[7] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h0000_0001, 32'h0000_0000, 32'h0000_0000};

    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.wb_en = 1'b0;
    bus.wb_addr = '0; bus.wb_data = '0; bus.out_ready = 1'b0;
    bus_w.imem_ack = 1'b0; bus_w.imem_rdata = '0; bus_w.wb_en = 1'b0;
    bus_w.wb_addr = '0; bus_w.wb_data = '0; bus_w.out_ready = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_req",   {31'd0, bus.imem_req},  32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    chk("rst_gr1",   bus.out_gr1,   32'd0);
    chk("rst_addr",  bus.imem_addr, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    chk("wrap_rst_addr", bus_w.imem_addr, 32'hFFFF_FFFC);

    rst = 1'b0;
    step();
    chk("first_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'd0);

    // Write RF[7] and fetch it so pc moves away from RESET_PC
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h0000_0055;
    step();
    bus.wb_en = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0007_0000;
    step();
    bus.imem_ack = 1'b0;
    chk("pre_gr1", bus.out_gr1, 32'h0000_0055);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("pre_addr4", bus.imem_addr, 32'd4);

    // Reset mid-FETCH with an ack pending
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_req",   {31'd0, bus.imem_req},  32'd0);
    chk("mid_rst_instr", bus.out_instr, 32'd0);
    chk("mid_rst_gr1",   bus.out_gr1,   32'd0);
    chk("mid_rst_addr",  bus.imem_addr, 32'd0);
    step();
    chk("mid_rst_drop_instr", bus.out_instr, 32'd0);
    chk("mid_rst_state", {30'd0, state_dbg}, 32'd0);
    rst = 1'b0; bus.imem_ack = 1'b0;
    step();
    chk("restart_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("restart_addr", bus.imem_addr, 32'd0);

    // Table-driven fetches
    exp_pc = 32'd0;
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre_en) begin
        bus.wb_en = 1'b1; bus.wb_addr = vecs[i].pre_addr; bus.wb_data = vecs[i].pre_data;
        step();
        bus.wb_en = 1'b0;
      end
      wait_req($sformatf("v%0d", i));
      chk($sformatf("v%0d_addr", i), bus.imem_addr, exp_pc);
      bus.imem_ack = 1'b1; bus.imem_rdata = vecs[i].rdata;
      bus.wb_en = vecs[i].ack_wb_en; bus.wb_addr = vecs[i].ack_wb_addr;
      bus.wb_data = vecs[i].ack_wb_data;
      step();
      bus.imem_ack = 1'b0; bus.wb_en = 1'b0; bus.imem_rdata = $urandom;
      chk($sformatf("v%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("v%0d_req0", i),  {31'd0, bus.imem_req},  32'd0);
      chk($sformatf("v%0d_instr", i), bus.out_instr, vecs[i].rdata);
      chk($sformatf("v%0d_gr1", i),   bus.out_gr1,   vecs[i].exp_gr1);
      if (i == 0) begin
        alu_c = bus.out_gr1 << bus.out_instr[10:6];
        chk("v0_alu_c", alu_c, 32'h0000_000C);
      end
      // Stray ack while holding is ignored
      bus.imem_ack = 1'b1;
      step();
      bus.imem_ack = 1'b0;
      chk($sformatf("v%0d_hold_instr", i), bus.out_instr, vecs[i].rdata);
      chk($sformatf("v%0d_hold_valid", i), {31'd0, bus.out_valid}, 32'd1);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      exp_pc = exp_pc + 32'd4;
      chk($sformatf("v%0d_xfer_valid", i), {31'd0, bus.out_valid}, 32'd0);
      chk($sformatf("v%0d_next_addr", i), bus.imem_addr, exp_pc);
    end

    // out_ready while out_valid=0 is ignored
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("idle_ready_state", {30'd0, state_dbg}, 32'd1);
    chk("idle_ready_valid", {31'd0, bus.out_valid}, 32'd0);

    // Stall with coherence: rt=12, RF[12] still 0 from reset
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h000C_4040;
    step();
    bus.imem_ack = 1'b0;
    chk("stall_gr1_init", bus.out_gr1, 32'd0);
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) begin
        bus.wb_en = 1'b1; bus.wb_addr = 5'd12; bus.wb_data = 32'h0000_1234;
      end
      step();
      bus.wb_en = 1'b0;
      chk($sformatf("stall%0d_valid", c), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("stall%0d_req0", c),  {31'd0, bus.imem_req},  32'd0);
      chk($sformatf("stall%0d_instr", c), bus.out_instr, 32'h000C_4040);
      chk($sformatf("stall%0d_gr1", c),   bus.out_gr1, (c >= 3) ? 32'h0000_1234 : 32'h0);
    end
    // Transfer and writeback to rt on the same edge
    bus.out_ready = 1'b1;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd12; bus.wb_data = 32'h0000_5678;
    step();
    bus.out_ready = 1'b0; bus.wb_en = 1'b0;
    chk("xwb_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h000C_0000;
    step();
    bus.imem_ack = 1'b0;
    chk("xwb_rf_gr1", bus.out_gr1, 32'h0000_5678);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // PC wrap on the RESET_PC=0xFFFF_FFFC instance
    chk("wrap_addr0", bus_w.imem_addr, 32'hFFFF_FFFC);
    bus_w.imem_ack = 1'b1; bus_w.imem_rdata = 32'h0000_0000;
    step();
    bus_w.imem_ack = 1'b0;
    chk("wrap_valid", {31'd0, bus_w.out_valid}, 32'd1);
    bus_w.out_ready = 1'b1;
    step();
    bus_w.out_ready = 1'b0;
    chk("wrap_req",  {31'd0, bus_w.imem_req}, 32'd1);
    chk("wrap_addr", bus_w.imem_addr, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
